// File: rtl/jtoutrun_ba0_arb_if.sv
// jtoutrun_ba0_arb_if: CPU-side request ports and SDRAM bank 0 signals of the bank 0 arbiter.
interface jtoutrun_ba0_arb_if #(parameter int AW = 22);
    logic          downloading;
    logic [2:0]    req_cs, req_we, req_ok;
    logic [AW-1:0] req_addr0, req_addr1, req_addr2, ba0_addr;
    logic [1:0]    req_dsn0, req_dsn1, ba0_din_m;
    logic [15:0]   req_din0, req_din1, req_dout, ba0_din, data_read;
    logic          ba_rd, ba_wr, ba_ack, ba_rdy;

    modport master (
        output downloading, req_cs, req_we, req_addr0, req_addr1, req_addr2,
               req_dsn0, req_dsn1, req_din0, req_din1, ba_ack, ba_rdy, data_read,
        input  req_dout, req_ok, ba0_addr, ba_rd, ba_wr, ba0_din, ba0_din_m
    );

    modport slave (
        input  downloading, req_cs, req_we, req_addr0, req_addr1, req_addr2,
               req_dsn0, req_dsn1, req_din0, req_din1, ba_ack, ba_rdy, data_read,
        output req_dout, req_ok, ba0_addr, ba_rd, ba_wr, ba0_din, ba0_din_m
    );
endinterface

// File: rtl/jtoutrun_ba0_arb.sv
// jtoutrun_ba0_arb: round-robin arbiter sharing SDRAM bank 0 between main RAM, sub RAM and main ROM.
module jtoutrun_ba0_arb #(parameter int AW = 22) (
    input logic               clk,
    input logic               rst_n,
    jtoutrun_ba0_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
    state_t        st;
    logic [1:0]    last, g, p0, p1, p2, sel, sel_dsn;
    logic [2:0]    done, pend;
    logic [AW-1:0] lat_addr [3];
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_din;
    logic          sel_we, we_l, fin;

    // ok is cached per port and only valid while the same address stays requested
    assign bus.req_ok = done & bus.req_cs & {bus.req_addr2 == lat_addr[2],
                                             bus.req_addr1 == lat_addr[1],
                                             bus.req_addr0 == lat_addr[0]};
    assign pend = bus.req_cs & ~bus.req_ok;
    assign p0 = last == 2'd2 ? 2'd0 : last + 2'd1;
    assign p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    assign sel = pend[p0] ? p0 : pend[p1] ? p1 : p2;
    assign sel_addr = sel == 2'd0 ? bus.req_addr0 : sel == 2'd1 ? bus.req_addr1 : bus.req_addr2;
    assign sel_we = sel != 2'd2 && bus.req_we[sel];
    assign sel_dsn = sel == 2'd0 ? bus.req_dsn0 : bus.req_dsn1;
    assign sel_din = sel == 2'd0 ? bus.req_din0 : bus.req_din1;
    // ack and rdy together in WAIT_ACK complete the access in one step
    assign fin = bus.ba_rdy && ((st == WAIT_ACK && bus.ba_ack) || st == WAIT_RDY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            last          <= 2'd2;
            g             <= 2'd0;
            done          <= 3'b000;
            we_l          <= 1'b0;
            lat_addr      <= '{default: '0};
            bus.ba_rd     <= 1'b0;
            bus.ba_wr     <= 1'b0;
            bus.ba0_addr  <= '0;
            bus.ba0_din   <= 16'h0;
            bus.ba0_din_m <= 2'b00;
            bus.req_dout  <= 16'h0;
        end else begin
            done <= done & bus.req_cs;
            case (st)
                IDLE: if (|pend && !bus.downloading) begin
                    g             <= sel;
                    we_l          <= sel_we;
                    lat_addr[sel] <= sel_addr;
                    done[sel]     <= 1'b0;
                    bus.ba0_addr  <= sel_addr;
                    bus.ba0_din   <= sel_din;
                    bus.ba0_din_m <= sel_we ? sel_dsn : 2'b00;
                    bus.ba_rd     <= !sel_we;
                    bus.ba_wr     <= sel_we;
                    st            <= WAIT_ACK;
                end
                WAIT_ACK: if (bus.ba_ack) begin
                    bus.ba_rd <= 1'b0;
                    bus.ba_wr <= 1'b0;
                    st        <= bus.ba_rdy ? IDLE : WAIT_RDY;
                end
                WAIT_RDY: if (bus.ba_rdy) st <= IDLE;
                default: st <= IDLE;
            endcase
            if (fin) begin
                if (!we_l) bus.req_dout <= bus.data_read;
                done[g] <= bus.req_cs[g];
                last    <= g;
            end
        end
    end
endmodule

// File: tb/tb_jtoutrun_ba0_arb.sv
// tb_jtoutrun_ba0_arb: directed scoreboard bench for the bank 0 arbiter with a simple SDRAM responder.
module tb_jtoutrun_ba0_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          passed = 0;
    int          ack_dly = 1;
    int          rdy_dly = 1;
    logic        same = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic [41:0] exp_q [$];

    jtoutrun_ba0_arb_if #(.AW(22)) bus();
    jtoutrun_ba0_arb #(.AW(22)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {addr, wr, rd, din (writes only), mask}
    function automatic logic [41:0] txn(input logic [21:0] a, input logic wr,
                                        input logic [15:0] d, input logic [1:0] m);
        return {a, wr, !wr, wr ? d : 16'h0, m};
    endfunction

    task automatic wait_ok(input logic [2:0] m, input string name);
        int n = 0;
        while ((bus.req_ok & m) != m && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(bus.req_ok & m), 64'(m));
    endtask

    // monitor: every new bank request is checked against the next expected transaction
    initial begin
        logic prev, cur;
        logic [41:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cur = bus.ba_rd | bus.ba_wr;
            if (cur && !prev) begin
                if (exp_q.size() == 0) chk("grant_expected", 64'(exp_q.size()), 64'd1);
                else begin
                    e = exp_q.pop_front();
                    chk("grant_txn", 64'({bus.ba0_addr, bus.ba_wr, bus.ba_rd,
                        bus.ba_wr ? bus.ba0_din : 16'h0, bus.ba0_din_m}), 64'(e));
                end
            end
            prev = cur;
        end
    end

    // SDRAM responder
    initial begin
        bus.ba_ack = 1'b0;
        bus.ba_rdy = 1'b0;
        bus.data_read = 16'h0;
        forever begin
            @(negedge clk);
            bus.ba_ack = 1'b0;
            bus.ba_rdy = 1'b0;
            if (rst_n && (bus.ba_rd || bus.ba_wr)) begin
                repeat (ack_dly - 1) @(negedge clk);
                bus.ba_ack = 1'b1;
                if (!same) begin
                    @(negedge clk);
                    bus.ba_ack = 1'b0;
                    repeat (rdy_dly - 1) @(negedge clk);
                end
                bus.ba_rdy = 1'b1;
                bus.data_read = rd_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        bus.downloading = 1'b0;
        bus.req_cs = 3'b000;
        bus.req_we = 3'b000;
        bus.req_addr0 = 22'h0;
        bus.req_addr1 = 22'h0;
        bus.req_addr2 = 22'h0;
        bus.req_dsn0 = 2'b11;
        bus.req_dsn1 = 2'b11;
        bus.req_din0 = 16'h0;
        bus.req_din1 = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.ba_rd, bus.ba_wr, bus.ba0_addr, bus.ba0_din,
            bus.ba0_din_m, bus.req_dout, bus.req_ok}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // single read on the ROM port
        ack_dly = 3; rdy_dly = 3; rd_data = 16'hBEEF;
        bus.req_addr2 = 22'h01234;
        bus.req_cs = 3'b100;
        exp_q.push_back(txn(22'h01234, 1'b0, 16'h0, 2'b00));
        @(negedge clk); chk("rd_cycle1", 64'(bus.ba_rd), 64'd1);
        repeat (2) @(negedge clk); chk("rd_cycle3", 64'(bus.ba_rd), 64'd1);
        @(negedge clk); chk("rd_cycle4", 64'(bus.ba_rd), 64'd0);
        repeat (2) @(negedge clk); chk("ok_cycle6", 64'(bus.req_ok[2]), 64'd0);
        @(negedge clk); chk("ok_cycle7", 64'({bus.req_ok, bus.req_dout}), 64'({3'b100, 16'hBEEF}));
        repeat (4) @(negedge clk); chk("ok_held", 64'(bus.req_ok), 64'(3'b100));
        bus.req_cs = 3'b000;
        #1 chk("ok_cs_drop", 64'(bus.req_ok), 64'd0);
        @(negedge clk);
        // masked write on main RAM, must not be re-issued while cs is held
        ack_dly = 1; rdy_dly = 2;
        bus.req_addr0 = 22'h00055;
        bus.req_we = 3'b001;
        bus.req_dsn0 = 2'b01;
        bus.req_din0 = 16'h5A5A;
        bus.req_cs = 3'b001;
        exp_q.push_back(txn(22'h00055, 1'b1, 16'h5A5A, 2'b01));
        wait_ok(3'b001, "wr_ok");
        chk("wr_dout_kept", 64'(bus.req_dout), 64'hBEEF);
        repeat (6) @(negedge clk); chk("wr_ok_held", 64'(bus.req_ok), 64'(3'b001));
        bus.req_cs = 3'b000;
        bus.req_we = 3'b000;
        @(negedge clk);
        // contention after reset: order 0,1,2 twice; ROM write strobe ignored
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_again", 64'({bus.ba_rd, bus.ba_wr, bus.ba0_addr, bus.ba0_din,
            bus.ba0_din_m, bus.req_dout, bus.req_ok}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        ack_dly = 1; rdy_dly = 1; rd_data = 16'h1234;
        bus.req_addr0 = 22'h10;
        bus.req_addr1 = 22'h20;
        bus.req_addr2 = 22'h30;
        bus.req_we = 3'b100;
        bus.req_cs = 3'b111;
        exp_q.push_back(txn(22'h10, 1'b0, 16'h0, 2'b00));
        exp_q.push_back(txn(22'h20, 1'b0, 16'h0, 2'b00));
        exp_q.push_back(txn(22'h30, 1'b0, 16'h0, 2'b00));
        wait_ok(3'b111, "rr1_all_ok");
        chk("rr1_dout", 64'(bus.req_dout), 64'h1234);
        bus.req_cs = 3'b000;
        @(negedge clk);
        rd_data = 16'h4321;
        bus.req_cs = 3'b111;
        exp_q.push_back(txn(22'h10, 1'b0, 16'h0, 2'b00));
        exp_q.push_back(txn(22'h20, 1'b0, 16'h0, 2'b00));
        exp_q.push_back(txn(22'h30, 1'b0, 16'h0, 2'b00));
        wait_ok(3'b111, "rr2_all_ok");
        chk("rr2_dout", 64'(bus.req_dout), 64'h4321);
        bus.req_cs = 3'b000;
        bus.req_we = 3'b000;
        @(negedge clk);
        // address change on sub RAM
        rd_data = 16'h1111;
        bus.req_addr1 = 22'h100;
        bus.req_cs = 3'b010;
        exp_q.push_back(txn(22'h100, 1'b0, 16'h0, 2'b00));
        wait_ok(3'b010, "addr_first_ok");
        chk("addr_first_dout", 64'(bus.req_dout), 64'h1111);
        rd_data = 16'h2222;
        bus.req_addr1 = 22'h101;
        exp_q.push_back(txn(22'h101, 1'b0, 16'h0, 2'b00));
        #1 chk("addr_change_ok_low", 64'(bus.req_ok[1]), 64'd0);
        wait_ok(3'b010, "addr_second_ok");
        chk("addr_second_dout", 64'(bus.req_dout), 64'h2222);
        bus.req_cs = 3'b000;
        @(negedge clk);
        // abort: port 0 drops cs while waiting for rdy
        ack_dly = 1; rdy_dly = 4; rd_data = 16'h3333;
        bus.req_addr0 = 22'h200;
        bus.req_addr1 = 22'h300;
        bus.req_cs = 3'b011;
        exp_q.push_back(txn(22'h200, 1'b0, 16'h0, 2'b00));
        exp_q.push_back(txn(22'h300, 1'b0, 16'h0, 2'b00));
        repeat (3) @(negedge clk);
        bus.req_cs = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | bus.req_ok[0];
        end
        chk("abort_next_grant", 64'({bus.ba_rd, bus.ba0_addr}), 64'({1'b1, 22'h300}));
        chk("abort_no_ok0", 64'(seen), 64'd0);
        wait_ok(3'b010, "abort_port1_ok");
        bus.req_cs = 3'b000;
        @(negedge clk);
        // ack and rdy in the same cycle, top address
        ack_dly = 2; same = 1'b1; rd_data = 16'hCAFE;
        bus.req_addr2 = 22'h3FFFFF;
        bus.req_cs = 3'b100;
        exp_q.push_back(txn(22'h3FFFFF, 1'b0, 16'h0, 2'b00));
        wait_ok(3'b100, "same_cycle_ok");
        chk("same_cycle_dout", 64'(bus.req_dout), 64'hCAFE);
        bus.req_cs = 3'b000;
        same = 1'b0;
        @(negedge clk);
        // downloading blocks grants
        ack_dly = 1; rdy_dly = 1; rd_data = 16'h7777;
        bus.downloading = 1'b1;
        bus.req_addr0 = 22'h400;
        bus.req_cs = 3'b001;
        repeat (5) @(negedge clk);
        chk("dl_no_grant", 64'({bus.ba_rd, bus.ba_wr, bus.req_ok}), 64'd0);
        bus.downloading = 1'b0;
        exp_q.push_back(txn(22'h400, 1'b0, 16'h0, 2'b00));
        wait_ok(3'b001, "dl_resume_ok");
        chk("dl_resume_dout", 64'(bus.req_dout), 64'h7777);
        bus.req_cs = 3'b000;
        @(negedge clk);
        // asynchronous reset during WAIT_ACK
        ack_dly = 30;
        bus.req_addr1 = 22'h500;
        bus.req_cs = 3'b010;
        exp_q.push_back(txn(22'h500, 1'b0, 16'h0, 2'b00));
        @(negedge clk);
        chk("rst_pre", 64'(bus.ba_rd), 64'd1);
        bus.req_cs = 3'b000;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({bus.ba_rd, bus.ba_wr, bus.ba0_addr, bus.req_dout, bus.req_ok}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
